spi_slave_rx: RTL
=================

Name: spi_slave_rx

Overview:
- SPI mode-0 slave front end, oversampled in the system clock domain.
- Deserialises MOSI into bytes and emits a one-cycle `spi_slave_data_valid` pulse with `spi_slave_byte`.
- These outputs drive the downstream 3-byte command listener directly.
- Also shifts a response byte out on MISO. Sits between the external SPI pins and the listener.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each of `sclk`, `cs_n`, `mosi`. Legal range 2..3.
- MSB_FIRST, 1: 1 = bit 7 is shifted first on MOSI and MISO; 0 = bit 0 first.

Ports:
- clk  input  1  system clock. All logic is in this domain.
- rst_n  input  1  asynchronous, active-low reset.
- spi_sclk  input  1  SPI clock from master, asynchronous to `clk`.
- spi_cs_n  input  1  SPI chip select, active low, asynchronous.
- spi_mosi  input  1  master-out data, asynchronous.
- spi_miso  output  1  slave-out data.
- tx_byte  input  8  response byte. Sampled at each byte-load point.
- spi_slave_byte  output  8  last fully received byte.
- spi_slave_data_valid  output  1  one-clk pulse when `spi_slave_byte` is updated.
- frame_err  output  1  one-clk pulse on a partial byte at CS release (optional feature).

Behaviour:
- Reset (`rst_n` low, async):
  - Synchroniser flops go to idle values: sclk=0, cs_n=1, mosi=0.
  - Bit counter = 0; rx and tx shift registers = 0.
  - `spi_slave_byte` = 8'h00, `spi_slave_data_valid` = 0, `spi_miso` = 0, `frame_err` = 0.
- Synchronisation and edges:
  - Each input passes through SYNC_STAGES flops.
  - One extra register on `sclk`/`cs_n` provides the previous value for edge detect.
  - sclk_rise, sclk_fall, cs_fall and cs_rise are single-clk pulses.
- Timing constraint: SCLK high and low phases must each be at least 3 clk periods. Faster SCLK is out of spec and behaviour is undefined.
- States: IDLE (synced cs_n=1) and ACTIVE (synced cs_n=0).
  - IDLE -> ACTIVE on cs_fall.
  - ACTIVE -> IDLE on cs_rise.
  - SCLK edges are ignored in IDLE.
- Receive:
  - In ACTIVE, on sclk_rise, synced mosi shifts into the rx shift register and the 3-bit bit counter increments.
  - MSB_FIRST=1: shift left, new bit in LSB. MSB_FIRST=0: shift right, new bit in MSB.
- Byte completion:
  - The sclk_rise that completes bit 8 (counter wraps 7 -> 0) registers the assembled byte into `spi_slave_byte`.
  - `spi_slave_data_valid` is 1 for exactly the next clk cycle.
  - Latency from the 8th SCLK rising edge at the pin to the valid pulse is SYNC_STAGES+2 clk cycles, ±1 for metastability.
  - `spi_slave_byte` holds its value until the next completion.
- Transmit:
  - On cs_fall, and on each byte completion, `tx_byte` is loaded into the tx shift register.
  - On cs_fall, `spi_miso` is driven immediately with the first bit (bit 7 if MSB_FIRST, else bit 0).
  - On each sclk_fall in ACTIVE, the next bit is presented. The sclk_fall after a byte completion presents the first bit of the newly loaded byte.
  - In IDLE, `spi_miso` = 0.
- cs_rise mid-byte:
  - Bit counter and rx shift register clear; no valid pulse.
  - The partial byte is discarded.
  - `spi_slave_byte` keeps its previous value.
- Simultaneous events:
  - cs_rise in the same cycle as sclk_rise: cs_rise wins. The edge is ignored and no byte completes.
  - cs_fall with sclk_rise: cs_fall handled first; the sclk edge is ignored.
- Back-to-back bytes under one CS: the counter continues and every 8 rising edges produce one pulse. There is no upper limit on byte count.
- Reset asserted mid-transfer: all state returns to reset values at once. After `rst_n` release, a new frame starts only on the next cs_fall; the first frame then waits for the next cs_fall.

Optional Feature:
- Macro SPI_SLAVE_FRAME_ERR_EN.
- Defined: on cs_rise with bit counter ≠ 0, `frame_err` pulses high for one clk.
- Not defined: `frame_err` is tied 0 and no extra logic is built.
- Receive/transmit behaviour is identical in both builds.

Test Plan:
- Reset then idle (cs_n=1, sclk toggling) -> no valid pulse, `spi_slave_byte`=8'h00, `spi_miso`=0.
- CS low, MOSI 8'h3A MSB-first, sclk = clk/8 -> one `spi_slave_data_valid` pulse, `spi_slave_byte`=8'h3A, pulse SYNC_STAGES+2 clks after the 8th rising edge.
- One CS frame carrying 8'h20, 8'h55, 8'hAA -> exactly three pulses with bytes 20, 55, AA in order. Feeding these to the listener yields `spi_data`=24'h2055AA.
- `tx_byte`=8'hC3 at cs_fall, then `tx_byte`=8'h5A before the 1st completion -> master samples MISO C3 then 5A.
- CS released after 5 bits of 8'hFF -> no valid pulse; byte unchanged. With SPI_SLAVE_FRAME_ERR_EN, `frame_err` pulses once; without it, it stays 0.
- `rst_n` pulsed low after 4 bits, then a fresh frame sending 8'h81 -> only 8'h81 is reported; no corrupted byte.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver/transmitter, oversampled in the clk domain.
// Define SPI_SLAVE_FRAME_ERR_EN to build the partial-byte frame_err pulse.
module spi_slave_rx #(
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] tx_byte,
    output logic [7:0] spi_slave_byte,
    output logic       spi_slave_data_valid,
    output logic       frame_err
);

    typedef enum logic {IDLE, ACTIVE} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic       sclk_prev_q, cs_prev_q;
    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d, rx_next;
    logic [7:0] tx_q, tx_d;
    logic [7:0] byte_q, byte_d;
    logic       valid_q, valid_d;
    logic       miso_q, miso_d;
    logic [2:0] tx_idx;

    assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // cnt_q is the number of bits already clocked in this byte,
    // so it also selects the next MISO bit to present.
    assign tx_idx = MSB_FIRST ? ~cnt_q : cnt_q;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        miso_d  = miso_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif
        rx_next = MSB_FIRST ? {rx_q[6:0], mosi_s}
                            : {mosi_s, rx_q[7:1]};
        if (cs_rise) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            rx_d    = 8'h00;
            miso_d  = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_d = (cnt_q != 3'd0);
`endif
        end else if (cs_fall) begin
            state_d = ACTIVE;
            cnt_d   = 3'd0;
            rx_d    = 8'h00;
            tx_d    = tx_byte;
            miso_d  = MSB_FIRST ? tx_byte[7] : tx_byte[0];
        end else if (state_q == ACTIVE) begin
            if (sclk_rise) begin
                rx_d  = rx_next;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    byte_d  = rx_next;
                    valid_d = 1'b1;
                    tx_d    = tx_byte;
                end
            end else if (sclk_fall) begin
                miso_d = tx_q[tx_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            byte_q      <= 8'h00;
            valid_q     <= 1'b0;
            miso_q      <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            miso_q      <= miso_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign spi_miso             = miso_q;
    assign spi_slave_byte       = byte_q;
    assign spi_slave_data_valid = valid_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule
